conv_result_sink: RTL



---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_result_sink_if.sv | 24 ++
 rtl/sink_ram.sv | 29 ++
 rtl/conv_result_sink.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv2d engine and its result sink.
package conv_pkg;

   localparam int unsigned IMG_W  = 50;
   localparam int unsigned IMG_H  = 50;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned ADDR_W = 17;
   localparam int unsigned N      = IMG_W * IMG_H;
   localparam int unsigned RAM_AW = $clog2(N);

   typedef enum logic [1:0] {
      ST_CLEAR    = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_PREFETCH = 2'd2,
      ST_DRAIN    = 2'd3
   } sink_state_t;

endpackage

// File: rtl/conv_result_sink_if.sv
// Write stream from conv2d plus the valid/ready drain stream toward the consumer.
interface conv_result_sink_if;
   import conv_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              frame_done;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output wr_en, wr_addr, wr_data, frame_done, out_ready,
      input  out_data, out_valid, out_last
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, frame_done, out_ready,
      output out_data, out_valid, out_last
   );

endinterface

// File: rtl/sink_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered read.
module sink_ram
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RAM_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RAM_AW-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [N];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the read register is reset so the drained output starts at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= mem[raddr];
   end

   assign rdata = rd_data_q;

endmodule

// File: rtl/conv_result_sink.sv
// Captures one conv2d output frame, then drains it in raster order over valid/ready.
// Optional CONV_SINK_CLEAR_EN: zero the frame store after reset and after each drain.
module conv_result_sink
   import conv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   conv_result_sink_if.slave    bus,
   output logic                 busy,
   output logic [ADDR_W-1:0]    pix_cnt,
   output logic                 err_oob,
   output logic                 err_ovr
);

`ifdef CONV_SINK_CLEAR_EN
   localparam sink_state_t IDLE_ST = ST_CLEAR;
`else
   localparam sink_state_t IDLE_ST = ST_CAPTURE;
`endif
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   sink_state_t       state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              err_oob_q, err_oob_d;
   logic              err_ovr_q, err_ovr_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              busy_q, busy_d;

   logic              fire;
   logic              in_range;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_waddr, ram_raddr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   // Next-state, RAM port steering and status updates.
   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      pix_cnt_d = pix_cnt_q;
      err_oob_d = err_oob_q;
      err_ovr_d = err_ovr_q;
      ram_we    = 1'b0;
      ram_waddr = RAM_AW'(bus.wr_addr);
      ram_wdata = bus.wr_data;
      ram_raddr = '0;
      fire      = out_valid_q & bus.out_ready;
      in_range  = bus.wr_addr < ADDR_W'(N);

      if (bus.wr_en && state_q != ST_CAPTURE) err_ovr_d = 1'b1;

      unique case (state_q)
         ST_CAPTURE: begin
            if (bus.wr_en) begin
               if (in_range) begin
                  ram_we = 1'b1;
                  if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + ADDR_W'(1);
               end else begin
                  err_oob_d = 1'b1;
               end
            end
            if (bus.frame_done) state_d = ST_PREFETCH;
         end
         ST_PREFETCH: state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (fire) begin
               if (rd_ptr_q == LAST) begin
                  rd_ptr_d  = '0;
                  pix_cnt_d = '0;
                  state_d   = IDLE_ST;
               end else begin
                  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               end
            end
            // Look one word ahead on fire so the stream has no bubbles.
            ram_raddr = RAM_AW'(rd_ptr_d);
         end
`ifdef CONV_SINK_CLEAR_EN
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = RAM_AW'(rd_ptr_q);
            ram_wdata = '0;
            if (rd_ptr_q == LAST) begin
               rd_ptr_d = '0;
               state_d  = ST_CAPTURE;
            end else begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
         end
`endif
         default: state_d = IDLE_ST;
      endcase

      out_valid_d = (state_d == ST_DRAIN);
      out_last_d  = (state_d == ST_DRAIN) && (rd_ptr_d == LAST);
      busy_d      = (state_d != ST_CAPTURE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE_ST;
         rd_ptr_q    <= '0;
         pix_cnt_q   <= '0;
         err_oob_q   <= 1'b0;
         err_ovr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= (IDLE_ST != ST_CAPTURE);
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         pix_cnt_q   <= pix_cnt_d;
         err_oob_q   <= err_oob_d;
         err_ovr_q   <= err_ovr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   sink_ram u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign bus.out_data  = ram_rdata;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;
   assign pix_cnt       = pix_cnt_q;
   assign err_oob       = err_oob_q;
   assign err_ovr       = err_ovr_q;

endmodule
